sc_dmem_io: RTL and testbench
=============================

// Module: sc_dmem_io
// PURPOSE
//  Data-side memory stage consuming the single-cycle CPU's store/load outputs (alu address, data, wmem)
//  and returning the load word on mem. Combines word-addressed data RAM with memory-mapped I/O:
//  output port, synchronised input port, transmit FIFO with valid/ready drain, and compare timer with interrupt.
//  Reads are combinational so a load completes in the CPU's single cycle; all writes commit on the clock edge.
// PARAMETERS
//  RAM_WORDS   32  data RAM depth in 32-bit words (power of 2); index = addr[log2(RAM_WORDS)+1:2]
//  FIFO_DEPTH  4   TX FIFO entries (power of 2, >=2)
// PORTS
//  clock     in   1   single clock, all state updates on rising edge
//  reset     in   1   asynchronous, active-high; clears all registers (not RAM)
//  addr      in   32  byte address from CPU ALU result; addr[1:0] ignored
//  datain    in   32  store data from CPU register file port B
//  we        in   1   store strobe from CPU wmem
//  dataout   out  32  load data to CPU mem input, combinational from addr
//  out_port  out  32  output port register
//  in_port   in   32  asynchronous external input port
//  tx_data   out  32  FIFO head word
//  tx_valid  out  1   FIFO non-empty
//  tx_ready  in   1   consumer accepts head this cycle
//  irq       out  1   timer interrupt = irq_flag & irq_en
// BEHAVIOUR
//  Map: addr[31]=0 -> RAM. addr[31]=1 -> IO, reg sel = addr[4:2]:
//   0 OUT  RW   out_port
//   1 IN   RO   in_sync (2-flop synchroniser of in_port; reads lag in_port by 2 clocks)
//   2 TX   W: push datain; R: {26'b0, ovf, full, empty, count[2:0]} (count saturates in field at 7)
//   3 CNT  RW   timer count
//   4 CMP  RW   timer compare
//   5 CTL  R: {29'b0, irq_flag, irq_en, tmr_en}; W: tmr_en=d[0], irq_en=d[1], d[2]=1 clears irq_flag, d[3]=1 clears ovf
//   6,7 read 0, writes ignored. addr[30:5] ignored for IO.
//  RAM: write mem[idx]<=datain when we&~addr[31]; no reset; read of a just-written word shows new data next cycle.
//  Reset values: out_port=0, in_sync=0, FIFO empty (tx_valid=0, tx_data=0), ovf=0, CNT=0, CMP=0, tmr_en=0,
//   irq_en=0, irq_flag=0, irq=0.
//  FIFO: circular buffer, rd/wr pointers wrap modulo FIFO_DEPTH, separate count (0..FIFO_DEPTH).
//   pop = tx_valid & tx_ready; push_req = we & IO & sel==2.
//   push accepted if count<FIFO_DEPTH or pop same cycle (full+push+pop: count unchanged, both pointers advance).
//   push_req rejected when full and no pop: data dropped, ovf<=1 (sticky until CTL d[3]).
//   empty+push: tx_valid rises next cycle (no bypass); tx_data stable while tx_valid & ~tx_ready.
//   tx_data = storage[rd_ptr] when non-empty, 0 when empty.
//  Timer: priority per cycle: CPU write CNT > match > increment.
//   tmr_en & CNT==CMP: CNT<=0, irq_flag<=1. Else tmr_en: CNT<=CNT+1 (wraps FFFFFFFF->0). tmr_en=0: CNT holds.
//   CPU write to CNT loads datain; no match evaluated that cycle.
//   irq_flag set (match) and clear (CTL d[2]) same cycle: set wins.
//   CMP write takes effect for the comparison in the following cycle.
//  irq combinational from flops (glitch-free); no dedicated latency beyond register update.
//  Reset asserted mid-operation: FIFO contents discarded, pointers/count zeroed, timer stops; RAM retained.
// TESTING
//  1 reset, store 0x12345678 to 0x00000010, load 0x00000010 -> dataout=0x12345678; load 0x80000000 -> 0.
//  2 store 0xA5A5A5A5 to 0x80000000 -> out_port=0xA5A5A5A5 next cycle; in_port=0x55 -> IN reads 0x55 after 2 clocks.
//  3 tx_ready=0, push 1..5 (DEPTH 4) -> status full=1,count=4,ovf=1; raise tx_ready -> tx_data 1,2,3,4 on consecutive clocks, then tx_valid=0.
//  4 FIFO full, tx_ready=1, push 9 same cycle -> count stays 4, 9 emerges last, ovf unchanged.
//  5 CMP=3, CTL=0x3 -> CNT 0,1,2,3,0; irq=1 after match; CTL write 0x7 on match cycle -> irq_flag stays 1; later 0x7 -> irq=0.
//  6 push 2 words, assert reset mid-drain -> tx_valid=0, status empty, out_port=0, RAM word from test 1 still readable.

Source files
------------

// File: rtl/sc_dmem_io.sv
// sc_dmem_io: data-side memory stage for the single-cycle CPU.
// addr[31]=0 selects a word-addressed data RAM. addr[31]=1 selects the IO
// block, with the register chosen by addr[4:2]:
//   0 OUT  RW  output port
//   1 IN   RO  in_port after a 2-flop synchroniser
//   2 TX   W pushes datain into the TX FIFO
//          R {ovf, full, empty, count[2:0]}
//   3 CNT  RW  timer count
//   4 CMP  RW  timer compare
//   5 CTL  R {irq_flag, irq_en, tmr_en}
//          W d0=tmr_en, d1=irq_en, d2 clears irq_flag, d3 clears ovf
//   6,7 read as 0; writes are ignored.
// Reads are combinational from addr, so a load completes in the same cycle.
// All writes commit on the rising clock edge.
// Ports:
//   clock, reset         clock; asynchronous active-high reset (RAM is not reset)
//   addr, datain, we     CPU store/load interface
//   dataout              load data
//   out_port, in_port    output port / asynchronous external input
//   tx_data, tx_valid    TX FIFO head word and non-empty flag
//   tx_ready             consumer takes the head this cycle
//   irq                  timer interrupt
module sc_dmem_io #(
  parameter int RAM_WORDS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic [31:0] out_port,
  input  logic [31:0] in_port,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] SEL_OUT = 3'd0;
  localparam logic [2:0] SEL_IN  = 3'd1;
  localparam logic [2:0] SEL_TX  = 3'd2;
  localparam logic [2:0] SEL_CNT = 3'd3;
  localparam logic [2:0] SEL_CMP = 3'd4;
  localparam logic [2:0] SEL_CTL = 3'd5;

  logic          is_io;
  logic [2:0]    sel;
  logic [AW-1:0] idx;
  logic          wr_io;
  logic          unused_addr;

  assign is_io       = addr[31];
  assign sel         = addr[4:2];
  assign idx         = addr[AW+1:2];
  assign wr_io       = we & is_io;
  // Byte-offset bits and the high IO bits do not take part in decode.
  assign unused_addr = ^{addr[30:5], addr[1:0]};

  // Data RAM. It has no reset, so its contents survive a reset.
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (we & ~is_io) mem[idx] <= datain;
  end

  // Output port register and input synchroniser.
  logic [31:0] in_meta;
  logic [31:0] in_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_port <= '0;
      in_meta  <= '0;
      in_sync  <= '0;
    end else begin
      if (wr_io && sel == SEL_OUT) out_port <= datain;
      in_meta <= in_port;
      in_sync <= in_meta;
    end
  end

  // TX FIFO: a circular buffer with an explicit occupancy count.
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          ovf;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic [31:0]   count_w;
  logic [2:0]    cnt_fld;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : fifo_mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  assign push_req = wr_io && sel == SEL_TX;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign count_w  = 32'(count);
  assign cnt_fld  = (count_w > 32'd7) ? 3'd7 : count_w[2:0];

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok & ~pop)      count <= count + 1'b1;
      else if (~push_ok & pop) count <= count - 1'b1;
      if (push_req & ~push_ok)                   ovf <= 1'b1;
      else if (wr_io && sel == SEL_CTL && datain[3]) ovf <= 1'b0;
    end
  end

  // Compare timer. Each cycle the priority is: CPU write to CNT, then match, then increment.
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        tmr_en;
  logic        irq_en;
  logic        irq_flag;
  logic        wr_cnt;
  logic        wr_ctl;
  logic        match;

  assign wr_cnt = wr_io && sel == SEL_CNT;
  assign wr_ctl = wr_io && sel == SEL_CTL;
  assign match  = tmr_en && (cnt == cmp) && !wr_cnt;
  assign irq    = irq_flag & irq_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      cmp      <= '0;
      tmr_en   <= 1'b0;
      irq_en   <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_cnt)      cnt <= datain;
      else if (match)  cnt <= '0;
      else if (tmr_en) cnt <= cnt + 32'd1;
      if (wr_io && sel == SEL_CMP) cmp <= datain;
      if (wr_ctl) begin
        tmr_en <= datain[0];
        irq_en <= datain[1];
      end
      // If a match sets the flag in the same cycle that software clears it, the set wins.
      if (match)                    irq_flag <= 1'b1;
      else if (wr_ctl && datain[2]) irq_flag <= 1'b0;
    end
  end

  // Load path.
  always_comb begin
    dataout = '0;
    if (!is_io) begin
      dataout = mem[idx];
    end else begin
      case (sel)
        SEL_OUT: dataout = out_port;
        SEL_IN:  dataout = in_sync;
        SEL_TX:  dataout = {26'b0, ovf, full, empty, cnt_fld};
        SEL_CNT: dataout = cnt;
        SEL_CMP: dataout = cmp;
        SEL_CTL: dataout = {29'b0, irq_flag, irq_en, tmr_en};
        default: dataout = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_dmem_io.sv
// Directed testbench for sc_dmem_io. Inputs change 1 time unit after the
// rising edge. Each check goes through the chk task.
module tb_sc_dmem_io;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, datain, dataout, out_port, in_port, tx_data;
  logic        we, tx_valid, tx_ready, irq;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] A_OUT = 32'h8000_0000;
  localparam logic [31:0] A_IN  = 32'h8000_0004;
  localparam logic [31:0] A_TX  = 32'h8000_0008;
  localparam logic [31:0] A_CNT = 32'h8000_000C;
  localparam logic [31:0] A_CMP = 32'h8000_0010;
  localparam logic [31:0] A_CTL = 32'h8000_0014;
  localparam logic [31:0] A_R6  = 32'h8000_0018;

  sc_dmem_io #(.RAM_WORDS(32), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .addr(addr), .datain(datain), .we(we),
    .dataout(dataout), .out_port(out_port), .in_port(in_port),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; datain = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dataout, exp);
  endtask

  initial begin
    reset = 1'b1; addr = '0; datain = '0; we = 1'b0; in_port = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    chk("rst_out", out_port, 32'h0);
    chk("rst_txv", {31'b0, tx_valid}, 32'h0);
    chk("rst_txd", tx_data, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst_stat", A_TX, 32'h0000_0008);

    // Test 1: RAM store and load.
    store(32'h0000_0010, 32'h1234_5678);
    rd_chk("ram_rd", 32'h0000_0010, 32'h1234_5678);
    rd_chk("io_out0", A_OUT, 32'h0);

    // Test 2: output port, input synchroniser, and an unused register slot.
    store(A_OUT, 32'hA5A5_A5A5);
    chk("out_port", out_port, 32'hA5A5_A5A5);
    rd_chk("out_rd", A_OUT, 32'hA5A5_A5A5);
    in_port = 32'h55;
    tick();
    rd_chk("in_lag1", A_IN, 32'h0);
    tick();
    rd_chk("in_lag2", A_IN, 32'h55);
    store(A_R6, 32'hDEAD_BEEF);
    rd_chk("r6_zero", A_R6, 32'h0);

    // Test 3: overfill the FIFO, then drain it.
    for (int i = 1; i <= 5; i++) store(A_TX, 32'(i));
    rd_chk("ovf_stat", A_TX, 32'h0000_0034);
    chk("full_txv", {31'b0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d", i), tx_data, 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    chk("drained_txv", {31'b0, tx_valid}, 32'h0);
    chk("drained_txd", tx_data, 32'h0);

    // Test 4: fill the FIFO, then push and pop in the same cycle.
    for (int i = 5; i <= 8; i++) store(A_TX, 32'(i));
    addr = A_TX; datain = 32'd9; we = 1'b1; tx_ready = 1'b1;
    tick();
    we = 1'b0; tx_ready = 1'b0;
    rd_chk("pp_stat", A_TX, 32'h0000_0034);
    tx_ready = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      chk($sformatf("pp_drain%0d", i), tx_data, 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    store(A_CTL, 32'h8);
    rd_chk("ovf_clr", A_TX, 32'h0000_0008);

    // Test 5: compare timer and interrupt.
    store(A_CMP, 32'd3);
    store(A_CTL, 32'h3);
    rd_chk("ctl_rd", A_CTL, 32'h3);
    for (int i = 0; i <= 3; i++) begin
      rd_chk($sformatf("cnt%0d", i), A_CNT, 32'(i));
      if (i < 3) tick();
    end
    chk("irq_pre", {31'b0, irq}, 32'h0);
    tick();
    rd_chk("cnt_wrap", A_CNT, 32'h0);
    chk("irq_set", {31'b0, irq}, 32'h1);
    rd_chk("ctl_flag", A_CTL, 32'h7);
    tick(); tick(); tick();
    rd_chk("cnt3b", A_CNT, 32'd3);
    store(A_CTL, 32'h7);           // clear lands on the match cycle
    chk("irq_setwins", {31'b0, irq}, 32'h1);
    rd_chk("cnt_wrap2", A_CNT, 32'h0);
    store(A_CTL, 32'h7);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    rd_chk("cnt_after", A_CNT, 32'h1);

    // Test 6: assert reset while the FIFO is draining.
    store(A_TX, 32'h11);
    store(A_TX, 32'h22);
    tx_ready = 1'b1;
    tick();
    chk("mid_txd", tx_data, 32'h22);
    reset = 1'b1;
    #1;
    chk("rst2_txv", {31'b0, tx_valid}, 32'h0);
    chk("rst2_out", out_port, 32'h0);
    chk("rst2_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst2_stat", A_TX, 32'h0000_0008);
    rd_chk("rst2_cnt", A_CNT, 32'h0);
    tx_ready = 1'b0;
    reset = 1'b0;
    tick();
    rd_chk("ram_keep", 32'h0000_0010, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
